// File: rtl/conv_out_ctrl_pkg.sv
// conv_ctrl_pkg
// Shared types and elaboration helpers for the convolution output-RAM
// write-address generator (conv_out_ctrl and its counters).
//   conv_state_e : frame sequencing state
//   cntWidth     : counter width for a modulo-n counter, never below 1 bit
//   frameSize    : number of RAM words one full output frame occupies
package conv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } conv_state_e;

    // Width of clog2(max(n,2)): a single-value counter still needs one bit.
    function automatic int cntWidth(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic longint frameSize(input int w, input int h, input int c);
        return longint'(w) * longint'(h) * longint'(c);
    endfunction

endpackage

// File: rtl/conv_out_ctrl_if.sv
// conv_out_ctrl_if
// Result-strobe in / RAM-write out bundle of the output controller.
//   ConvValid_i  : frame enable level (low aborts and rearms)
//   vbit_i       : one convolution result valid this cycle
//   OutRamAddr_o : RAM write address
//   OutRamWe_o   : RAM write enable
//   OutRamCh_o   : channel of the current write
//   ConvReady_o  : frame complete level
//   ConvDone_o   : one-cycle completion pulse
//   OvfErr_o     : sticky write-past-frame flag
// master = conv engine side, slave = controller side.
interface conv_out_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int CH_W   = 1
);
    logic              ConvValid_i;
    logic              vbit_i;
    logic [ADDR_W-1:0] OutRamAddr_o;
    logic              OutRamWe_o;
    logic [CH_W-1:0]   OutRamCh_o;
    logic              ConvReady_o;
    logic              ConvDone_o;
    logic              OvfErr_o;

    modport master (
        output ConvValid_i, vbit_i,
        input  OutRamAddr_o, OutRamWe_o, OutRamCh_o,
        input  ConvReady_o, ConvDone_o, OvfErr_o
    );

    modport slave (
        input  ConvValid_i, vbit_i,
        output OutRamAddr_o, OutRamWe_o, OutRamCh_o,
        output ConvReady_o, ConvDone_o, OvfErr_o
    );
endinterface

// File: rtl/conv_out_ctrl_cnt_wrap.sv
// cnt_wrap
// Modulo-MOD up counter with enable, synchronous clear and a last flag.
//   clk  : clock
//   rstn : synchronous active-low reset
//   clr  : synchronous clear (priority over en)
//   en   : advance by one, wrapping to 0 after MOD-1
//   cnt  : current count
//   last : cnt == MOD-1 (always 1 when MOD == 1)
module cnt_wrap #(
    parameter int MOD = 2,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         last
);
    localparam logic [W-1:0] MAX = W'(MOD - 1);

    assign last = (cnt == MAX);

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/conv_out_ctrl.sv
// conv_out_ctrl
// Write-address generator for a convolution layer's output RAM. Results
// arrive channel-serial per pixel (pixels row-major) and are stored
// channel-major: addr = ch*OUT_W*OUT_H + row*OUT_W + col, built from
// running base registers so no multiplier is needed.
//   clk  : clock, rising edge
//   rstn : synchronous active-low reset
//   bus  : conv_out_ctrl_if slave (strobe in, RAM write/status out)
//
// state | meaning
// IDLE  | armed, counters at zero, next accept writes address 0
// RUN   | frame in progress
// DONE  | frame written, counters frozen, further vbits flag overflow
module conv_out_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int OUT_W  = 5,
    parameter int OUT_H  = 5,
    parameter int N_CH   = 1,
    parameter int ADDR_W = 5
) (
    input logic             clk,
    input logic             rstn,
    conv_out_ctrl_if.slave  bus
);
    localparam int CH_W  = cntWidth(N_CH);
    localparam int COL_W = cntWidth(OUT_W);
    localparam int ROW_W = cntWidth(OUT_H);

    localparam logic [ADDR_W-1:0] CH_STEP  = ADDR_W'(OUT_W * OUT_H);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(OUT_W);

    generate
        if ((longint'(1) << ADDR_W) < frameSize(OUT_W, OUT_H, N_CH)) begin : g_addr_chk
            $error("conv_out_ctrl: ADDR_W too small for N_CH*OUT_W*OUT_H");
        end
    endgenerate

    conv_state_e       state;
    logic [ADDR_W-1:0] chBase;
    logic [ADDR_W-1:0] rowBase;
    logic              readyQ;
    logic              doneQ;
    logic              ovfQ;

    logic [CH_W-1:0]   chCnt;
    logic [COL_W-1:0]  colCnt;
    logic [ROW_W-1:0]  rowCntUnused;
    logic              chLast;
    logic              colLast;
    logic              rowLast;

    logic accept;
    logic pixAdv;
    logic rowAdv;
    logic lastElem;

    assign accept   = bus.vbit_i & bus.ConvValid_i & (state != DONE);
    assign pixAdv   = accept & chLast;
    assign rowAdv   = pixAdv & colLast;
    assign lastElem = chLast & colLast & rowLast;

    cnt_wrap #(.MOD(N_CH), .W(CH_W)) u_ch (
        .clk (clk),
        .rstn(rstn),
        .clr (~bus.ConvValid_i),
        .en  (accept),
        .cnt (chCnt),
        .last(chLast)
    );

    cnt_wrap #(.MOD(OUT_W), .W(COL_W)) u_col (
        .clk (clk),
        .rstn(rstn),
        .clr (~bus.ConvValid_i),
        .en  (pixAdv),
        .cnt (colCnt),
        .last(colLast)
    );

    // Only the wrap flag of the row counter matters; the row offset itself
    // is carried by rowBase.
    cnt_wrap #(.MOD(OUT_H), .W(ROW_W)) u_row (
        .clk (clk),
        .rstn(rstn),
        .clr (~bus.ConvValid_i),
        .en  (rowAdv),
        .cnt (rowCntUnused),
        .last(rowLast)
    );

    always_ff @(posedge clk) begin
        if (!rstn || !bus.ConvValid_i) begin
            state   <= IDLE;
            chBase  <= '0;
            rowBase <= '0;
            readyQ  <= 1'b0;
            doneQ   <= 1'b0;
            ovfQ    <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            if (accept) begin
                chBase <= chLast ? '0 : chBase + CH_STEP;
            end
            if (rowAdv) begin
                rowBase <= rowLast ? '0 : rowBase + ROW_STEP;
            end
            case (state)
                IDLE, RUN: begin
                    if (accept) begin
                        if (lastElem) begin
                            state  <= DONE;
                            readyQ <= 1'b1;
                            doneQ  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                DONE: begin
                    if (bus.vbit_i) begin
                        ovfQ <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.OutRamAddr_o = chBase + rowBase + ADDR_W'(colCnt);
    assign bus.OutRamWe_o   = accept;
    assign bus.OutRamCh_o   = chCnt;
    assign bus.ConvReady_o  = readyQ;
    assign bus.ConvDone_o   = doneQ;
    assign bus.OvfErr_o     = ovfQ;
endmodule
